// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register: valid/ready handshake, flush, stored PC+step values and stall counter.
// Define IFID_PIPE_REG_SKID_EN to add a skid entry, which makes in_ready a flop output.
module ifid_pipe_reg #(
  parameter int              INS_W   = 32,
  parameter int              PC_W    = 32,
  parameter logic [INS_W-1:0] NOP_INS = '0,
  parameter int              PC_STEP = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INS_W-1:0] in_ins,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INS_W-1:0] out_ins,
  output logic [PC_W-1:0]  out_pc,
  output logic [PC_W-1:0]  out_pc4,
  output logic [PC_W-1:0]  out_pc8,
  output logic [31:0]      stall_cnt
);

  localparam logic [PC_W-1:0] STEP1 = PC_W'(PC_STEP);
  localparam logic [PC_W-1:0] STEP2 = PC_W'(2 * PC_STEP);

  logic             r_m_valid;
  logic [INS_W-1:0] r_m_ins;
  logic [PC_W-1:0]  r_m_pc;
  logic [PC_W-1:0]  r_m_pc4;
  logic [PC_W-1:0]  r_m_pc8;
  logic [31:0]      r_stall_cnt;

  logic             w_accept;
  logic             w_emit;
  logic [PC_W-1:0]  w_in_pc4;
  logic [PC_W-1:0]  w_in_pc8;

  assign w_accept = in_valid && in_ready;
  assign w_emit   = r_m_valid && out_ready;
  assign w_in_pc4 = in_pc + STEP1;
  assign w_in_pc8 = in_pc + STEP2;

`ifdef IFID_PIPE_REG_SKID_EN
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic [INS_W-1:0] r_s_ins;
  logic [PC_W-1:0]  r_s_pc;

  assign in_ready = r_in_ready;

  // S is occupied exactly in ST_FULL, so the state doubles as s_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
      r_m_valid  <= 1'b0;
      r_m_ins    <= '0;
      r_m_pc     <= '0;
      r_m_pc4    <= '0;
      r_m_pc8    <= '0;
      r_s_ins    <= '0;
      r_s_pc     <= '0;
    end else if (flush) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
      r_m_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_m_valid <= 1'b1;
            r_m_ins   <= in_ins;
            r_m_pc    <= in_pc;
            r_m_pc4   <= w_in_pc4;
            r_m_pc8   <= w_in_pc8;
            r_state   <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && !w_emit) begin
            r_s_ins    <= in_ins;
            r_s_pc     <= in_pc;
            r_in_ready <= 1'b0;
            r_state    <= ST_FULL;
          end else if (w_accept) begin
            r_m_ins <= in_ins;
            r_m_pc  <= in_pc;
            r_m_pc4 <= w_in_pc4;
            r_m_pc8 <= w_in_pc8;
          end else if (w_emit) begin
            r_m_valid <= 1'b0;
            r_state   <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_emit) begin
            r_m_ins    <= r_s_ins;
            r_m_pc     <= r_s_pc;
            r_m_pc4    <= r_s_pc + STEP1;
            r_m_pc8    <= r_s_pc + STEP2;
            r_in_ready <= 1'b1;
            r_state    <= ST_ONE;
          end
        end
        default: begin
          r_state    <= ST_EMPTY;
          r_in_ready <= 1'b1;
          r_m_valid  <= 1'b0;
        end
      endcase
    end
  end
`else
  assign in_ready = !r_m_valid || out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m_valid <= 1'b0;
      r_m_ins   <= '0;
      r_m_pc    <= '0;
      r_m_pc4   <= '0;
      r_m_pc8   <= '0;
    end else if (flush) begin
      r_m_valid <= 1'b0;
    end else if (w_accept) begin
      r_m_valid <= 1'b1;
      r_m_ins   <= in_ins;
      r_m_pc    <= in_pc;
      r_m_pc4   <= w_in_pc4;
      r_m_pc8   <= w_in_pc8;
    end else if (w_emit) begin
      r_m_valid <= 1'b0;
    end
  end
`endif

  // Saturating; deliberately survives flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (r_m_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign out_valid = r_m_valid;
  assign out_ins   = r_m_valid ? r_m_ins : NOP_INS;
  assign out_pc    = r_m_pc;
  assign out_pc4   = r_m_pc4;
  assign out_pc8   = r_m_pc8;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_ifid_pipe_reg.sv
// Directed bench for ifid_pipe_reg; covers plain and IFID_PIPE_REG_SKID_EN builds.
module tb_ifid_pipe_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IFID_PIPE_REG_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_ins, in_pc, out_ins, out_pc, out_pc4, out_pc8, stall_cnt;
  int          checks = 0;
  int          errors = 0;

  ifid_pipe_reg #(.INS_W(32), .PC_W(32), .NOP_INS(NOP), .PC_STEP(4)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins),
    .out_pc(out_pc), .out_pc4(out_pc4), .out_pc8(out_pc8), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", out_valid); end
    checks++; if (out_ins !== NOP) begin errors++; $display("FAIL reset_ins got %h exp %h", out_ins, NOP); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", out_pc); end
    checks++; if (out_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h exp 0", out_pc4); end
    checks++; if (out_pc8 !== 32'h0) begin errors++; $display("FAIL reset_pc8 got %h exp 0", out_pc8); end
    checks++; if (stall_cnt !== 32'h0) begin errors++; $display("FAIL reset_stall got %h exp 0", stall_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0h exp 1", in_ready); end
    $display("reset: valid=%0h ins=%h in_ready=%0h", out_valid, out_ins, in_ready);
  endtask

  task automatic test_stream();
    in_valid = 1'b1; in_ins = 32'h8C01_0004; in_pc = 32'h3000; out_ready = 1'b1;
    cycle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream0_valid got %0h exp 1", out_valid); end
    checks++; if (out_ins !== 32'h8C01_0004) begin errors++; $display("FAIL stream0_ins got %h exp 8c010004", out_ins); end
    checks++; if (out_pc !== 32'h3000) begin errors++; $display("FAIL stream0_pc got %h exp 3000", out_pc); end
    checks++; if (out_pc4 !== 32'h3004) begin errors++; $display("FAIL stream0_pc4 got %h exp 3004", out_pc4); end
    checks++; if (out_pc8 !== 32'h3008) begin errors++; $display("FAIL stream0_pc8 got %h exp 3008", out_pc8); end
    $display("stream beat0: ins=%h pc=%h pc4=%h pc8=%h", out_ins, out_pc, out_pc4, out_pc8);
    @(negedge clk); in_ins = 32'h8C02_0008; in_pc = 32'h3004;
    cycle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream1_valid got %0h exp 1", out_valid); end
    checks++; if (out_ins !== 32'h8C02_0008) begin errors++; $display("FAIL stream1_ins got %h exp 8c020008", out_ins); end
    checks++; if (out_pc !== 32'h3004) begin errors++; $display("FAIL stream1_pc got %h exp 3004", out_pc); end
    checks++; if (out_pc4 !== 32'h3008) begin errors++; $display("FAIL stream1_pc4 got %h exp 3008", out_pc4); end
    checks++; if (out_pc8 !== 32'h300C) begin errors++; $display("FAIL stream1_pc8 got %h exp 300c", out_pc8); end
    $display("stream beat1: ins=%h pc=%h pc4=%h pc8=%h", out_ins, out_pc, out_pc4, out_pc8);
    @(negedge clk); in_valid = 1'b0;
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid got %0h exp 0", out_valid); end
    checks++; if (out_ins !== NOP) begin errors++; $display("FAIL stream_drain_ins got %h exp %h", out_ins, NOP); end
    checks++; if (out_pc !== 32'h3004) begin errors++; $display("FAIL stream_drain_pc got %h exp 3004", out_pc); end
    $display("stream drain: valid=%0h ins=%h pc=%h", out_valid, out_ins, out_pc);
    @(negedge clk);
  endtask

  task automatic test_wrap();
    in_valid = 1'b1; in_ins = 32'h0000_1234; in_pc = 32'hFFFF_FFFC; out_ready = 1'b1;
    cycle();
    checks++; if (out_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h exp fffffffc", out_pc); end
    checks++; if (out_pc4 !== 32'h0000_0000) begin errors++; $display("FAIL wrap_pc4 got %h exp 00000000", out_pc4); end
    checks++; if (out_pc8 !== 32'h0000_0004) begin errors++; $display("FAIL wrap_pc8 got %h exp 00000004", out_pc8); end
    $display("wrap beat: pc=%h pc4=%h pc8=%h", out_pc, out_pc4, out_pc8);
    @(negedge clk); in_valid = 1'b0;
    cycle();
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_ins = 32'hAAAA_0001; in_pc = 32'h4000; out_ready = 1'b0;
    cycle();
    checks++; if (out_ins !== 32'hAAAA_0001) begin errors++; $display("FAIL bp_load_ins got %h exp aaaa0001", out_ins); end
    @(negedge clk); in_ins = 32'hBBBB_0002; in_pc = 32'h4004;
    #1;
    checks++; if (in_ready !== SKID) begin errors++; $display("FAIL bp_first_in_ready got %0h exp %0h", in_ready, SKID); end
    cycle();
    for (int i = 1; i < 5; i++) begin
      @(negedge clk); in_valid = !SKID;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got %0h exp 0", i, in_ready); end
      checks++; if (out_ins !== 32'hAAAA_0001) begin errors++; $display("FAIL bp_hold_ins%0d got %h exp aaaa0001", i, out_ins); end
      cycle();
    end
    checks++; if (stall_cnt !== 32'd5) begin errors++; $display("FAIL bp_stall got %0d exp 5", stall_cnt); end
    checks++; if (out_pc !== 32'h4000) begin errors++; $display("FAIL bp_hold_pc got %h exp 4000", out_pc); end
    $display("backpressure held: ins=%h stall=%0d", out_ins, stall_cnt);
    @(negedge clk); out_ready = 1'b1; in_valid = !SKID;
    cycle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_rel_valid got %0h exp 1", out_valid); end
    checks++; if (out_ins !== 32'hBBBB_0002) begin errors++; $display("FAIL bp_rel_ins got %h exp bbbb0002", out_ins); end
    checks++; if (out_pc4 !== 32'h4008) begin errors++; $display("FAIL bp_rel_pc4 got %h exp 4008", out_pc4); end
    $display("backpressure release: ins=%h pc=%h", out_ins, out_pc);
    @(negedge clk); in_valid = 1'b0;
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_valid got %0h exp 0", out_valid); end
    checks++; if (stall_cnt !== 32'd5) begin errors++; $display("FAIL bp_drain_stall got %0d exp 5", stall_cnt); end
    @(negedge clk);
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_ins = 32'hCCCC_0003; in_pc = 32'h5000; out_ready = 1'b0;
    cycle();
    @(negedge clk); in_ins = 32'hDDDD_0004; in_pc = 32'h5004;
    #1;
    checks++; if (in_ready !== SKID) begin errors++; $display("FAIL flush_fill_in_ready got %0h exp %0h", in_ready, SKID); end
    cycle();
    @(negedge clk); in_ins = 32'hEEEE_0005; in_pc = 32'h5008; flush = 1'b1; out_ready = 1'b1;
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0h exp 0", out_valid); end
    checks++; if (out_ins !== NOP) begin errors++; $display("FAIL flush_ins got %h exp %h", out_ins, NOP); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %0h exp 1", in_ready); end
    checks++; if (stall_cnt !== 32'd6) begin errors++; $display("FAIL flush_stall got %0d exp 6", stall_cnt); end
    $display("flush: valid=%0h ins=%h stall=%0d", out_valid, out_ins, stall_cnt);
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_after%0d valid got %0h ins %h exp 0", i, out_valid, out_ins); end
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_ins = 32'hFFFF_0006; in_pc = 32'h6000; out_ready = 1'b0;
    cycle();
    @(negedge clk); in_valid = 1'b0;
    cycle();
    checks++; if (stall_cnt !== 32'd7) begin errors++; $display("FAIL arst_pre_stall got %0d exp 7", stall_cnt); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %0h exp 1", out_valid); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %0h exp 0", out_valid); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL arst_stall got %0d exp 0", stall_cnt); end
    checks++; if (out_ins !== NOP) begin errors++; $display("FAIL arst_ins got %h exp %h", out_ins, NOP); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL arst_pc got %h exp 0", out_pc); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready got %0h exp 1", in_ready); end
    $display("async reset: valid=%0h stall=%0d", out_valid, stall_cnt);
    @(negedge clk); reset_n = 1'b1; out_ready = 1'b1;
  endtask

  task automatic test_saturation();
    force dut.r_stall_cnt = 32'hFFFF_FFFE;
    #1 release dut.r_stall_cnt;
    in_valid = 1'b1; in_ins = 32'h1111_0007; in_pc = 32'h7000; out_ready = 1'b0;
    cycle();
    checks++; if (stall_cnt !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_preload got %h exp fffffffe", stall_cnt); end
    @(negedge clk); in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (stall_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold%0d got %h exp ffffffff", i, stall_cnt); end
      $display("saturation cycle %0d: stall=%h", i, stall_cnt);
    end
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ins = '0; in_pc = '0; out_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk); reset_n = 1'b1;
    test_stream();
    test_wrap();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
